// File: rtl/branch_control.sv
// rtl/branch_control.sv - ID-stage branch sequencer: operand hazard stall, condition evaluation, PC redirect
module branch_control #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              br_valid,
    input  logic [2:0]        br_code,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] target,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [4:0]        mem_rd,
    input  logic              mem_mem_read,
    output logic              stall,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   pc_target_q;
    logic [CNT_W-1:0]    branch_cnt_q, taken_cnt_q;

    logic                uses_ops, is_branch, cond_taken, evaluate;
    logic [1:0]          h_rs, h_rt, h;

    assign uses_ops  = (br_code >= 3'd1) && (br_code <= 3'd4);
    assign is_branch = br_valid && (br_code >= 3'd1) && (br_code <= 3'd5);

    // Load in EX needs two cycles to reach the forward path; ALU result in EX or load in MEM needs one.
    always_comb begin
        h_rs = 2'd0;
        if (rs_addr != 5'd0) begin
            if (ex_mem_read && ex_rd == rs_addr)
                h_rs = 2'd2;
            else if ((ex_reg_write && ex_rd == rs_addr) || (mem_mem_read && mem_rd == rs_addr))
                h_rs = 2'd1;
        end
        h_rt = 2'd0;
        if (rt_addr != 5'd0) begin
            if (ex_mem_read && ex_rd == rt_addr)
                h_rt = 2'd2;
            else if ((ex_reg_write && ex_rd == rt_addr) || (mem_mem_read && mem_rd == rt_addr))
                h_rt = 2'd1;
        end
        h = 2'd0;
        if (uses_ops)
            h = (h_rs > h_rt) ? h_rs : h_rt;
    end

    always_comb begin
        cond_taken = 1'b0;
        case (br_code)
            3'd1:    cond_taken = (rs_data == rt_data);
            3'd2:    cond_taken = (rs_data != rt_data);
            3'd3:    cond_taken = ($signed(rs_data) > $signed(rt_data));
            3'd4:    cond_taken = ($signed(rs_data) < $signed(rt_data));
            3'd5:    cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        pc_load    = 1'b0;
        flush_ifid = 1'b0;
        evaluate   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_branch) begin
                    if (h != 2'd0) begin
                        stall   = 1'b1;
                        cnt_d   = h - 2'd1;
                        state_d = S_WAIT;
                    end else begin
                        evaluate = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Instruction vanished from ID (external flush): drop it without counting.
                if (!is_branch) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 2'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    evaluate = 1'b1;
                end
            end
            S_REDIRECT: begin
                pc_load    = 1'b1;
                flush_ifid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (evaluate)
            state_d = cond_taken ? S_REDIRECT : S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            pc_target_q  <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (evaluate) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
                if (cond_taken) begin
                    taken_cnt_q <= taken_cnt_q + 1'b1;
                    pc_target_q <= target;
                end
            end
        end
    end

    assign pc_target    = pc_target_q;
    assign branch_count = branch_cnt_q;
    assign taken_count  = taken_cnt_q;

endmodule
